adder_tree_pipe: RTL and testbench
==================================

// Module: adder_tree_pipe
// PURPOSE
//  Parametrised, valid-tagged pipelined reduction tree for the pool_nl path; successor to the fixed 32-lane tree.
//  Sums N_IN signed PE outputs (per-lane masked) in log2(N_IN) registered stages at full precision.
//  Optionally accumulates consecutive beats (multi-pass channel/window reduction) until a beat tagged last.
//  Delivers one saturated OUT_W result per group to the pooling / non-linearity stage.
// PARAMETERS
//  N_IN     32  input lane count; power of two, >= 2
//  IN_W     16  signed width of each lane
//  OUT_W    16  signed width of adder_tree_out; must be <= ACC_W
//  ACC_EXT   8  extra accumulator guard bits beyond tree growth
//  (derived) LG = $clog2(N_IN); TREE_W = IN_W+LG; ACC_W = TREE_W+ACC_EXT
// PORTS
//  clk                 in   1           clock, rising edge
//  rst                 in   1           asynchronous, active-high reset
//  adder_enable        in   1           pipeline advance; 0 freezes every stage, valid and sideband
//  acc_mode            in   1           0: one result per beat; 1: accumulate beats until in_last
//  in_valid            in   1           beat present on output_mac_packed
//  in_last             in   1           final beat of group (acc_mode=1 only)
//  mac_enable          in   N_IN        per-lane mask; 0 forces lane to zero
//  output_mac_packed   in   N_IN*IN_W   lane i at bits [i*IN_W +: IN_W], signed
//  adder_tree_out      out  OUT_W       saturated signed result
//  out_valid           out  1           one-cycle strobe, result valid
//  out_sat             out  1           result was clipped (with out_valid)
//  busy                out  1           any stage valid or accumulation open
// BEHAVIOUR
//  Reset: every stage register, accumulator, adder_tree_out, out_valid, out_sat, busy = 0; FSM = IDLE.
//  Input sampled only when adder_enable=1; lanes masked, sign-extended to TREE_W before stage 1.
//  Stage k (1..LG) registers N_IN/2^k pair sums; no truncation inside the tree (TREE_W sufficient).
//  in_valid, in_last, acc_mode travel as sideband registers alongside data through all LG stages.
//  Output stage (stage LG+1) registered: latency = LG+1 enabled cycles (6 for N_IN=32).
//  adder_enable=0: all state holds; latency extends by stalled cycles; no beat is lost or duplicated.
//  Bubbles (in_valid=0) propagate; they never update accumulator nor raise out_valid.
//  FSM at output stage, evaluated on a valid beat arriving from stage LG:
//   IDLE, mode=0             -> emit tree sum; stay IDLE.
//   IDLE, mode=1, last=0     -> acc = sum (sign-ext to ACC_W); go ACCUM.
//   IDLE, mode=1, last=1     -> single-beat group: emit sum; stay IDLE.
//   ACCUM, last=0            -> acc += sum; stay ACCUM.
//   ACCUM, last=1            -> emit acc+sum; clear acc; go IDLE.
//   ACCUM, mode=0 beat       -> protocol error: open group discarded, beat emitted as mode 0; go IDLE.
//  Accumulator wraps modulo 2^ACC_W (guard bits sized so this is out of spec use).
//  Emit: clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 iff clipped; out_valid=1 for one enabled cycle.
//  adder_tree_out holds last emitted value until next emit; out_sat cleared with next emit.
//  busy = OR of stage valids | (FSM==ACCUM); deassert only when drained.
//  Reset mid-operation: in-flight beats and open group discarded; no out_valid after reset release.
// TESTING
//  (N_IN=32, IN_W=16, OUT_W=16, ACC_EXT=8)
//  T1: all lanes 1, mask all-ones, mode 0, one valid beat -> out_valid 6 cycles later, out=32, out_sat=0.
//  T2: lanes=5, mask=0x0000_0001 then mask=0 next beat -> back-to-back outputs 5 then 0.
//  T3: all lanes 32767 -> out=32767, out_sat=1; all lanes -32768 -> out=-32768, out_sat=1.
//  T4: mode 1, three beats of lanes=1, last on third -> exactly one out_valid, out=96; none for beats 1-2.
//  T5: back-to-back beats, adder_enable low 3 cycles mid-flight -> results arrive 3 cycles later, values and order intact.
//  T6: rst asserted while ACCUM with two beats in tree -> all outputs 0; next group (one last beat, lanes=2) -> 64.

Source files
------------

// File: rtl/adder_tree_pipe.sv
// Masked, valid-tagged pipelined reduction tree with optional multi-beat accumulation
// and a saturating output stage feeding the pooling / non-linearity path.
module adder_tree_pipe #(
  parameter int unsigned N_IN    = 32,
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned ACC_EXT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adder_enable,
  input  logic                 acc_mode,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [N_IN-1:0]      mac_enable,
  input  logic [N_IN*IN_W-1:0] output_mac_packed,
  output logic [OUT_W-1:0]     adder_tree_out,
  output logic                 out_valid,
  output logic                 out_sat,
  output logic                 busy
);

  localparam int unsigned LG     = $clog2(N_IN);
  localparam int unsigned TREE_W = IN_W + LG;
  localparam int unsigned ACC_W  = TREE_W + ACC_EXT;
  localparam int unsigned NODES  = N_IN - 1;

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  // Tree nodes stored flat: node j sums src[2j] and src[2j+1], where src is the
  // masked lanes followed by all non-root nodes, so each stage feeds the next.
  logic signed [TREE_W-1:0] lane_ext [N_IN];
  logic signed [TREE_W-1:0] src      [2*N_IN-2];
  logic signed [TREE_W-1:0] node_d   [NODES];
  logic signed [TREE_W-1:0] node_q   [NODES];

  logic [LG-1:0] vld_d, vld_q;
  logic [LG-1:0] last_d, last_q;
  logic [LG-1:0] mode_d, mode_q;

  state_e                  state_d, state_q;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic signed [ACC_W-1:0] beat_sum;
  logic signed [ACC_W-1:0] emit_val;
  logic signed [ACC_W-1:0] emit_hi;
  logic                    emit;
  logic                    clip;
  logic [OUT_W-1:0]        out_d, out_q;
  logic                    out_valid_d, out_valid_q;
  logic                    out_sat_d, out_sat_q;

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      lane_ext[i] = '0;
      if (mac_enable[i]) begin
        lane_ext[i] = TREE_W'($signed(output_mac_packed[i*IN_W +: IN_W]));
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      src[i] = lane_ext[i];
    end
    for (int i = 0; i < N_IN - 2; i++) begin
      src[N_IN + i] = node_q[i];
    end
    for (int j = 0; j < NODES; j++) begin
      node_d[j] = src[2*j] + src[2*j+1];
    end
  end

  always_comb begin
    vld_d[0]  = in_valid;
    last_d[0] = in_last;
    mode_d[0] = acc_mode;
    for (int k = 1; k < LG; k++) begin
      vld_d[k]  = vld_q[k-1];
      last_d[k] = last_q[k-1];
      mode_d[k] = mode_q[k-1];
    end
  end

  // Group FSM acts only on valid beats leaving the last tree stage.
  always_comb begin
    beat_sum = ACC_W'(node_q[NODES-1]);
    state_d  = state_q;
    acc_d    = acc_q;
    emit     = 1'b0;
    emit_val = beat_sum;
    if (vld_q[LG-1]) begin
      unique case (state_q)
        StIdle: begin
          if (mode_q[LG-1] && !last_q[LG-1]) begin
            acc_d   = beat_sum;
            state_d = StAccum;
          end else begin
            emit = 1'b1;
          end
        end
        StAccum: begin
          if (!mode_q[LG-1]) begin
            // A mode-0 beat aborts the open group and passes through on its own.
            acc_d   = '0;
            state_d = StIdle;
            emit    = 1'b1;
          end else if (!last_q[LG-1]) begin
            acc_d = acc_q + beat_sum;
          end else begin
            emit     = 1'b1;
            emit_val = acc_q + beat_sum;
            acc_d    = '0;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Value fits OUT_W only when every bit above the OUT_W sign bit matches it.
  always_comb begin
    emit_hi     = emit_val >>> (OUT_W - 1);
    clip        = (emit_hi != '0) && (emit_hi != '1);
    out_d       = out_q;
    out_sat_d   = out_sat_q;
    out_valid_d = emit;
    if (emit) begin
      out_sat_d = clip;
      if (!clip) begin
        out_d = emit_val[OUT_W-1:0];
      end else if (emit_val[ACC_W-1]) begin
        out_d = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        out_d = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NODES; j++) begin
        node_q[j] <= '0;
      end
      vld_q       <= '0;
      last_q      <= '0;
      mode_q      <= '0;
      state_q     <= StIdle;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else if (adder_enable) begin
      for (int j = 0; j < NODES; j++) begin
        node_q[j] <= node_d[j];
      end
      vld_q       <= vld_d;
      last_q      <= last_d;
      mode_q      <= mode_d;
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign adder_tree_out = out_q;
  assign out_valid      = out_valid_q;
  assign out_sat        = out_sat_q;
  assign busy           = (|vld_q) | (state_q == StAccum);

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe: directed scenarios plus a randomized run, all
// compared against a group-level arithmetic model of the reduction.
module tb_adder_tree_pipe;
  localparam int N_IN    = 32;
  localparam int IN_W    = 16;
  localparam int OUT_W   = 16;
  localparam int ACC_EXT = 8;
  localparam int LG      = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 adder_enable;
  logic                 acc_mode;
  logic                 in_valid;
  logic                 in_last;
  logic [N_IN-1:0]      mac_enable;
  logic [N_IN*IN_W-1:0] output_mac_packed;
  logic [OUT_W-1:0]     adder_tree_out;
  logic                 out_valid;
  logic                 out_sat;
  logic                 busy;

  adder_tree_pipe #(
    .N_IN   (N_IN),
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .ACC_EXT(ACC_EXT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .adder_enable     (adder_enable),
    .acc_mode         (acc_mode),
    .in_valid         (in_valid),
    .in_last          (in_last),
    .mac_enable       (mac_enable),
    .output_mac_packed(output_mac_packed),
    .adder_tree_out   (adder_tree_out),
    .out_valid        (out_valid),
    .out_sat          (out_sat),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint val;
    int     due;
  } exp_t;

  int           n_cmp = 0;
  int           n_err = 0;
  int           lane_val[N_IN];
  exp_t         expq[$];
  int           edge_cnt = 0;
  int           last_vld_edge = -100;
  bit           grp_open = 1'b0;
  longint       grp_sum = 0;
  logic [15:0]  hold_out = '0;
  logic         hold_sat = 1'b0;
  logic         hold_vld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_result(longint v);
    exp_t e;
    e.val = v;
    e.due = edge_cnt + LG;
    expq.push_back(e);
  endfunction

  // Group semantics straight from the mode/last rules.
  function automatic void model_beat(longint s, logic md, logic lst);
    if (!md) begin
      push_result(s);
      grp_open = 1'b0;
      grp_sum  = 0;
    end else if (!grp_open) begin
      if (lst) push_result(s);
      else begin
        grp_open = 1'b1;
        grp_sum  = s;
      end
    end else begin
      grp_sum += s;
      if (lst) begin
        push_result(grp_sum);
        grp_open = 1'b0;
        grp_sum  = 0;
      end
    end
  endfunction

  task automatic clip16(input longint v, output logic [15:0] o, output logic sat);
    if (v > 32767) begin
      o = 16'h7fff; sat = 1'b1;
    end else if (v < -32768) begin
      o = 16'h8000; sat = 1'b1;
    end else begin
      o = v[15:0]; sat = 1'b0;
    end
  endtask

  task automatic cycle(input logic en, input logic v, input logic md, input logic lst);
    longint s;
    logic   exp_busy;
    adder_enable = en;
    in_valid     = v;
    acc_mode     = md;
    in_last      = lst;
    for (int i = 0; i < N_IN; i++) output_mac_packed[i*IN_W +: IN_W] = lane_val[i][IN_W-1:0];
    @(posedge clk);
    #1;
    if (en) begin
      edge_cnt++;
      if (v) begin
        s = 0;
        for (int i = 0; i < N_IN; i++) if (mac_enable[i]) s += longint'(lane_val[i]);
        last_vld_edge = edge_cnt;
        model_beat(s, md, lst);
      end
      if (expq.size() > 0 && expq[0].due == edge_cnt) begin
        chk("out_valid", 32'(out_valid), 32'd1);
        clip16(expq[0].val, hold_out, hold_sat);
        chk("out", 32'(adder_tree_out), 32'(hold_out));
        chk("out_sat", 32'(out_sat), 32'(hold_sat));
        void'(expq.pop_front());
        hold_vld = 1'b1;
      end else begin
        chk("out_valid_idle", 32'(out_valid), 32'd0);
        hold_vld = 1'b0;
      end
    end else begin
      chk("stall_valid", 32'(out_valid), 32'(hold_vld));
      chk("stall_out", 32'(adder_tree_out), 32'(hold_out));
    end
    exp_busy = grp_open || (edge_cnt - last_vld_edge <= LG - 1);
    chk("busy", 32'(busy), 32'(exp_busy));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_lanes(input int v);
    for (int i = 0; i < N_IN; i++) lane_val[i] = v;
  endtask

  task automatic rand_lanes();
    logic signed [15:0] r;
    for (int i = 0; i < N_IN; i++) begin
      r = 16'($urandom);
      lane_val[i] = r;
    end
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_out"}, 32'(adder_tree_out), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sat"}, 32'(out_sat), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic model_clear();
    expq.delete();
    grp_open      = 1'b0;
    grp_sum       = 0;
    last_vld_edge = -100;
    hold_out      = '0;
    hold_sat      = 1'b0;
    hold_vld      = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    adder_enable      = 1'b0;
    acc_mode          = 1'b0;
    in_valid          = 1'b0;
    in_last           = 1'b0;
    mac_enable        = '0;
    output_mac_packed = '0;
    set_lanes(0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_check("reset");
    rst = 1'b0;

    // T1: all ones, one beat -> 32 after six enabled edges
    set_lanes(1);
    mac_enable = '1;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    drain(7);

    // T2: single-lane mask then full mask-off, back to back
    set_lanes(5);
    mac_enable = 32'h0000_0001;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    mac_enable = '0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    drain(7);

    // T3: saturation both ways
    mac_enable = '1;
    set_lanes(32767);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    set_lanes(-32768);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    drain(7);

    // T4: three-beat accumulation -> 96
    set_lanes(1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    drain(7);

    // T5: back-to-back beats with a three-cycle stall mid-flight
    for (int b = 0; b < 4; b++) begin
      rand_lanes();
      mac_enable = $urandom;
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    drain(8);

    // Aborted group: open with mode 1, then a mode-0 beat stands alone
    mac_enable = '1;
    set_lanes(7);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    set_lanes(-3);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    drain(7);

    // T6: reset while accumulating with two beats still in the tree
    set_lanes(3);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    drain(6);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    reset_check("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    set_lanes(2);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    drain(7);

    // Randomized beats, modes, masks and stalls
    for (int c = 0; c < 80; c++) begin
      rand_lanes();
      mac_enable = $urandom;
      cycle(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
    end
    drain(12);
    chk("drained", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
